// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path and the ALU decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_en;
    logic       pc_en;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       branch;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ   || op == OP_ADDI || op == OP_J;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Per-state datapath control decode; FETCH enables are the only mem_ready-gated outputs.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic [ST_W-1:0] state,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output ctrl_t           ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_W'(S_FETCH): begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        ctrl.ir_en     = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      ST_W'(S_DECODE): begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.illegal_op = !op_legal(6'(opcode));
      end
      ST_W'(S_MEMADR), ST_W'(S_ADDIEX): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ST_W'(S_MEMRD): begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      ST_W'(S_MEMWR): begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      ST_W'(S_MEMWB): begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_W'(S_EXEC): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_W'(S_ALUWB): begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_W'(S_ADDIWB): ctrl.reg_write = 1'b1;
      ST_W'(S_BRANCH): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.branch    = 1'b1;
        ctrl.pc_src    = PC_ALUOUT;
      end
      ST_W'(S_JUMP): begin
        ctrl.pc_src = PC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic, and output decode instance.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_write,
  output logic            iord,
  output logic            ir_en,
  output logic            pc_en,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            alu_src_a,
  output logic            branch,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic [ST_W-1:0] state,
  output logic            illegal_op
);

  logic [ST_W-1:0] state_q, state_d;
  logic [5:0]      op;
  ctrl_t           ctrl;

  assign op = 6'(opcode);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_W'(S_FETCH);
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_W'(S_FETCH);
    case (state_q)
      ST_W'(S_FETCH):  state_d = mem_ready ? ST_W'(S_DECODE) : ST_W'(S_FETCH);
      ST_W'(S_DECODE): begin
        case (op)
          OP_LW, OP_SW: state_d = ST_W'(S_MEMADR);
          OP_RTYPE:     state_d = ST_W'(S_EXEC);
          OP_BEQ:       state_d = ST_W'(S_BRANCH);
          OP_ADDI:      state_d = ST_W'(S_ADDIEX);
          OP_J:         state_d = ST_W'(S_JUMP);
          default:      state_d = ST_W'(S_FETCH);
        endcase
      end
      ST_W'(S_MEMADR): state_d = (op == OP_LW) ? ST_W'(S_MEMRD) : ST_W'(S_MEMWR);
      ST_W'(S_MEMRD):  state_d = mem_ready ? ST_W'(S_MEMWB) : ST_W'(S_MEMRD);
      ST_W'(S_MEMWR):  state_d = mem_ready ? ST_W'(S_FETCH) : ST_W'(S_MEMWR);
      ST_W'(S_EXEC):   state_d = ST_W'(S_ALUWB);
      ST_W'(S_ADDIEX): state_d = ST_W'(S_ADDIWB);
      default:         state_d = ST_W'(S_FETCH);
    endcase
  end

  mips_ctrl_outdec #(.OP_W(OP_W), .ST_W(ST_W)) u_outdec (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Architectural write strobes are squashed while reset is held so no stale update lands.
  assign mem_req    = ctrl.mem_req;
  assign mem_write  = ctrl.mem_write & ~reset;
  assign iord       = ctrl.iord;
  assign ir_en      = ctrl.ir_en     & ~reset;
  assign pc_en      = ctrl.pc_en     & ~reset;
  assign reg_write  = ctrl.reg_write & ~reset;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign branch     = ctrl.branch;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign illegal_op = ctrl.illegal_op;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for the multicycle control FSM with a per-cycle expected-value queue.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req, mem_write, iord, ir_en, pc_en;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, branch;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
  } vec_t;

  typedef struct {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_en, pc_en, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, branch, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];
  exp_t sb[$];

  mips_multicycle_ctrl #(.OP_W(6), .ST_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_en(ir_en), .pc_en(pc_en),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .branch(branch), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Expected outputs for a given state, straight from the per-state control table.
  function automatic outs_t exp_outs(input logic [3:0] st, input logic [5:0] op,
                                     input logic mr, input logic rst);
    outs_t o = '0;
    case (st)
      4'd0:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_en = mr; o.pc_en = mr; end
      4'd1:  begin
        o.alu_src_b = 2'b11;
        o.illegal_op = !(op inside {LW, SW, RT, BEQ, ADDI, JMP});
      end
      4'd2, 4'd9: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      4'd3:  begin o.mem_req = 1; o.iord = 1; end
      4'd4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      4'd5:  begin o.mem_req = 1; o.mem_write = 1; o.iord = 1; end
      4'd6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      4'd7:  begin o.reg_write = 1; o.reg_dst = 1; end
      4'd8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.branch = 1; o.pc_src = 2'b01; end
      4'd10: o.reg_write = 1;
      4'd11: begin o.pc_src = 2'b10; o.pc_en = 1; end
      default: ;
    endcase
    if (rst) begin o.ir_en = 0; o.pc_en = 0; o.reg_write = 0; o.mem_write = 0; end
    return o;
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] st);
    tbl.push_back('{rst: r, op: op, mr: mr, st: st});
  endtask

  task automatic measure(input string name, input logic [5:0] op, input int want);
    int cyc = 0;
    reset = 0; opcode = op; mem_ready = 1;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (state != 4'd0 && cyc < 20);
    n_vec++;
    if (cyc != want) begin
      n_err++;
      $display("FAIL latency_%s: got %0d cycles, expected %0d", name, cyc, want);
    end
  endtask

  initial begin
    outs_t got;
    exp_t  e;
    reset = 1; opcode = RT; mem_ready = 1;
    repeat (2) @(posedge clk);

    // lw, no waits: 0,1,2,3,4
    add(0,LW,1,0); add(0,LW,1,1); add(0,LW,1,2); add(0,LW,1,3); add(0,LW,1,4);
    // sw with mem_ready low 3 cycles in MEMWR
    add(0,SW,1,0); add(0,SW,1,1); add(0,SW,1,2);
    add(0,SW,0,5); add(0,SW,0,5); add(0,SW,0,5); add(0,SW,1,5);
    // R-type with 2-cycle fetch stall; mem_ready ignored in EXEC/ALUWB
    add(0,RT,0,0); add(0,RT,0,0); add(0,RT,1,0); add(0,RT,1,1); add(0,RT,0,6); add(0,RT,0,7);
    // illegal opcode
    add(0,BAD,1,0); add(0,BAD,0,1);
    // addi
    add(0,ADDI,1,0); add(0,ADDI,1,1); add(0,ADDI,1,9); add(0,ADDI,1,10);
    // lw with one MEMRD wait
    add(0,LW,1,0); add(0,LW,1,1); add(0,LW,1,2); add(0,LW,0,3); add(0,LW,1,3); add(0,LW,1,4);
    // reset while waiting in MEMRD
    add(0,LW,1,0); add(0,LW,1,1); add(0,LW,1,2); add(0,LW,0,3); add(1,LW,0,3);
    // beq then j back-to-back
    add(0,BEQ,1,0); add(0,BEQ,1,1); add(0,BEQ,1,8); add(0,JMP,1,0); add(0,JMP,1,1); add(0,JMP,1,11);
    // reset in MEMWB squashes reg_write; reset in FETCH squashes ir_en/pc_en
    add(0,LW,1,0); add(0,LW,1,1); add(0,LW,1,2); add(0,LW,1,3); add(1,LW,1,4);
    add(1,RT,1,0); add(0,RT,1,0);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      reset = tbl[i].rst; opcode = tbl[i].op; mem_ready = tbl[i].mr;
      sb.push_back('{st: tbl[i].st, o: exp_outs(tbl[i].st, tbl[i].op, tbl[i].mr, tbl[i].rst)});
      @(negedge clk);
      e = sb.pop_front();
      got = {mem_req, mem_write, iord, ir_en, pc_en, reg_write, reg_dst, mem_to_reg,
             alu_src_a, branch, alu_src_b, alu_op, pc_src, illegal_op};
      n_vec++;
      if (state !== e.st || got !== e.o) begin
        n_err++;
        $display("FAIL vec%0d: state %0d outs %h, expected state %0d outs %h",
                 i, state, got, e.st, e.o);
      end
    end

    // last row held reset low in FETCH with mem_ready=1, so the next edge goes to DECODE
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    measure("lw", LW, 5);
    measure("sw", SW, 4);
    measure("rtype", RT, 4);
    measure("addi", ADDI, 4);
    measure("beq", BEQ, 3);
    measure("j", JMP, 3);
    measure("illegal", BAD, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter OP_W, default 6, opcode width.
REQ-002 SHALL have parameter ST_W, default 4, state-code width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 SHALL have port opcode  input  OP_W  instruction-register opcode field, bits [31:26].
REQ-006 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-007 SHALL have port mem_req  output  1  memory access request.
REQ-008 SHALL have port mem_write  output  1  access is a write; valid only with mem_req.
REQ-009 SHALL have port iord  output  1  address select: 0 = PC, 1 = ALUOut.
REQ-010 SHALL have port ir_en, pc_en  output  1 each  enable pulses for the instruction and PC registers.
REQ-011 SHALL have port reg_write, reg_dst, mem_to_reg, alu_src_a, branch  output  1 each  datapath controls.
REQ-012 SHALL have port alu_src_b, alu_op, pc_src  output  2 each  datapath mux and ALU-class selects.
REQ-013 SHALL have port state  output  ST_W  current state code, for debug.
REQ-014 SHALL have port illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-015 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-016 SHALL use these transitions: FETCH->DECODE when mem_ready, else hold; DECODE->MEMADR (lw 100011, sw 101011), EXEC (R-type 000000), BRANCH (beq 000100), ADDIEX (addi 001000), JUMP (j 000010); any other opcode->FETCH.
REQ-017 SHALL use these transitions: MEMADR->MEMRD (lw) or MEMWR (sw), using opcode held stable by the instruction register; MEMRD->MEMWB when mem_ready, else hold; MEMWR->FETCH when mem_ready, else hold.
REQ-018 SHALL use these transitions: MEMWB, ALUWB, ADDIWB, BRANCH and JUMP->FETCH; EXEC->ALUWB; ADDIEX->ADDIWB.
REQ-019 SHALL drive all outputs as 0 by default, overridden per state as in REQ-020 to REQ-024.
REQ-020 SHALL drive in FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_en=pc_en=mem_ready, the only Mealy-gated outputs.
REQ-021 SHALL drive in DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; illegal_op=1 for an unsupported opcode.
REQ-022 SHALL drive in MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; in MEMRD: mem_req=1, iord=1; in MEMWR: mem_req=1, mem_write=1, iord=1; in MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
REQ-023 SHALL drive in EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; in ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; in ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-024 SHALL drive in BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_src=01; in JUMP: pc_src=10, pc_en=1.
REQ-025 SHALL give these instruction latencies with mem_ready always 1: lw 5 cycles; sw, R-type, addi 4; beq, j 3; illegal opcode 2.
REQ-026 SHALL add exactly one cycle to an instruction for each cycle mem_ready is 0 in FETCH, MEMRD or MEMWR; mem_ready SHALL be ignored in all other states.

Reset
REQ-027 SHALL, when reset=1 at a rising edge, load state=FETCH regardless of the current state, including mid-wait in MEMRD/MEMWR.
REQ-028 SHALL, after reset, present FETCH outputs: mem_req=1, alu_src_b=01, all other outputs 0, ir_en/pc_en following mem_ready.
REQ-029 SHALL give reset priority over every transition; no register write or PC update SHALL occur in the reset cycle.

Structure
REQ-030 SHALL place state codes, opcode constants and alu_op/pc_src/alu_src_b encodings in package mips_ctrl_pkg, shared with the ALU decoder.
REQ-031 SHALL keep the state register and next-state logic in mips_multicycle_ctrl, and the output decode in one sub-module, mips_ctrl_outdec, fed by state, opcode and mem_ready.

Verification
REQ-032 SHALL cover: reset, then lw (100011) with mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-033 SHALL cover: sw with mem_ready held low 3 cycles in MEMWR -> state 5 for 4 cycles, mem_write=1 throughout, then FETCH.
REQ-034 SHALL cover: FETCH with mem_ready=0 for 2 cycles -> ir_en=pc_en=0 for those cycles, a 1-cycle pulse of both, then DECODE.
REQ-035 SHALL cover: opcode 111111 -> illegal_op=1 for one cycle in DECODE, FETCH next, no reg_write.
REQ-036 SHALL cover: reset asserted in MEMRD while waiting -> state=0 next cycle, reg_write never 1.
REQ-037 SHALL cover: beq then j back-to-back -> branch=1, pc_src=01 in state 8; pc_en=1, pc_src=10 in state 11; 3 cycles each.
